// File: rtl/branch_resolve_queue_pkg.sv
// Shared constants and the entry record for the branch resolve queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package branch_resolve_queue_pkg;

  // Default low PC index width, matching the branch history table index.
  localparam int LOWER_DEF = 5;

  // Default number of in-flight predicted branches.
  localparam int DEPTH_DEF = 4;

  // Read/write pointer width for the default depth.
  localparam int PTR_W = $clog2(DEPTH_DEF);

  // One in-flight branch: where it lives in the history table and what we predicted.
  typedef struct packed {
    logic [LOWER_DEF-1:0] addr;
    logic                 pred;
  } entry_t;

  // Resolved direction as seen by the predictor: a jump always counts as taken.
  function automatic logic resolved_outcome(input logic taken, input logic jump);
    return taken | jump;
  endfunction

endpackage

// File: rtl/branch_resolve_queue.sv
// Holds predicted branches in fetch order and retires them in order against execute results.
// Latency: push visible next cycle; resolve produces upd_en/mispredict one cycle later.
// Backpressure: none; a push when full without a same-cycle resolve is dropped and sets sticky err.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int LOWER = LOWER_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push_valid,
  input  logic [LOWER-1:0]         push_addr,
  input  logic                     push_pred,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     resolve_jump,
  input  logic                     flush,
  output logic                     upd_en,
  output logic [LOWER-1:0]         upd_addr,
  output logic                     upd_taken,
  output logic                     upd_jumped,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Pointer arithmetic relies on natural wrap, so the depth must be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("branch_resolve_queue: DEPTH must be a power of two and at least 2");
  end

  // Same layout as entry_t, sized by this instance's LOWER.
  typedef struct packed {
    logic [LOWER-1:0] addr;
    logic             pred;
  } slot_t;

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  slot_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           upd_en_q, upd_en_d;
  logic [LOWER-1:0] upd_addr_q, upd_addr_d;
  logic           upd_taken_q, upd_taken_d;
  logic           upd_jumped_q, upd_jumped_d;
  logic           mispredict_q, mispredict_d;
  logic           err_q, err_d;

  // Storage write port, computed alongside the next-state logic.
  logic           mem_we;
  slot_t          mem_wr_dat;

  // Decodes of registered occupancy only; no input reaches these.
  logic           is_full;
  logic           is_empty;

  // Per-cycle decisions.
  slot_t          head;
  logic           pop;
  logic           push_ok;
  logic           miss;
  logic           push_dropped;
  logic           resolve_ignored;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  // Oldest entry, read combinationally so the resolve can be judged this cycle.
  assign head = mem_q[rd_ptr_q];

  // Classify this cycle's push/resolve against the current occupancy.
  always_comb begin
    pop             = resolve_valid & ~is_empty;
    push_ok         = push_valid & (~is_full | resolve_valid);
    miss            = pop & (head.pred != resolved_outcome(resolve_taken, resolve_jump));
    push_dropped    = push_valid & is_full & ~resolve_valid;
    resolve_ignored = resolve_valid & is_empty;
  end

  // Next-state: flush wins outright, then a mispredict squashes, else normal push/pop.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    upd_en_d     = 1'b0;
    upd_addr_d   = upd_addr_q;
    upd_taken_d  = upd_taken_q;
    upd_jumped_d = upd_jumped_q;
    mispredict_d = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_wr_dat   = '{addr: push_addr, pred: push_pred};

    if (flush) begin
      // Everything in flight is gone; this cycle's push/resolve never happened.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_dropped || resolve_ignored) begin
        err_d = 1'b1;
      end

      if (pop) begin
        upd_en_d     = 1'b1;
        upd_addr_d   = head.addr;
        upd_taken_d  = resolve_taken;
        upd_jumped_d = resolve_jump;
        mispredict_d = miss;
      end

      if (miss) begin
        // Younger entries were fetched down the wrong path, as is any same-cycle push.
        rd_ptr_d = rd_ptr_q + AW'(1);
        wr_ptr_d = rd_ptr_q + AW'(1);
        count_d  = '0;
      end else begin
        if (push_ok) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Control and output registers; reset clears all in-flight state and pending pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      upd_en_q     <= 1'b0;
      upd_addr_q   <= '0;
      upd_taken_q  <= 1'b0;
      upd_jumped_q <= 1'b0;
      mispredict_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      upd_en_q     <= upd_en_d;
      upd_addr_q   <= upd_addr_d;
      upd_taken_q  <= upd_taken_d;
      upd_jumped_q <= upd_jumped_d;
      mispredict_q <= mispredict_d;
      err_q        <= err_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wr_dat;
    end
  end

  assign upd_en     = upd_en_q;
  assign upd_addr   = upd_addr_q;
  assign upd_taken  = upd_taken_q;
  assign upd_jumped = upd_jumped_q;
  assign mispredict = mispredict_q;
  assign full       = is_full;
  assign empty      = is_empty;
  assign count      = count_q;
  assign err        = err_q;

  // Occupancy can never exceed the storage.
  a_count_bound : assert property (@(posedge clk) disable iff (!arst_n)
    count_q <= CW'(DEPTH));

  // A redirect is always accompanied by its table update.
  a_miss_has_upd : assert property (@(posedge clk) disable iff (!arst_n)
    mispredict_q |-> upd_en_q);

  // The pointer gap must agree with the counter except when full.
  a_ptr_gap : assert property (@(posedge clk) disable iff (!arst_n)
    (count_q != CW'(DEPTH)) |-> (AW'(wr_ptr_q - rd_ptr_q) == AW'(count_q)));

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed table, corner sequences, random vs queue model.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  logic                 clk;
  logic                 arst_n;
  logic                 push_valid;
  logic [LOWER_DEF-1:0] push_addr;
  logic                 push_pred;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 resolve_jump;
  logic                 flush;
  logic                 upd_en;
  logic [LOWER_DEF-1:0] upd_addr;
  logic                 upd_taken;
  logic                 upd_jumped;
  logic                 mispredict;
  logic                 full;
  logic                 empty;
  logic [PTR_W:0]       count;
  logic                 err;

  int total = 0;
  int bad   = 0;

  branch_resolve_queue dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .push_valid    (push_valid),
    .push_addr     (push_addr),
    .push_pred     (push_pred),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .resolve_jump  (resolve_jump),
    .flush         (flush),
    .upd_en        (upd_en),
    .upd_addr      (upd_addr),
    .upd_taken     (upd_taken),
    .upd_jumped    (upd_jumped),
    .mispredict    (mispredict),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // ---------------- reference model: an ordered list of in-flight branches ----------------
  entry_t            mq[$];
  logic              m_err, m_upd, m_tk, m_jp, m_mis;
  logic [LOWER_DEF-1:0] m_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 0; push_addr = '0; push_pred = 0;
    resolve_valid = 0; resolve_taken = 0; resolve_jump = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    arst_n = 0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_upd_en", 32'(upd_en), 0);
    chk("rst_mispredict", 32'(mispredict), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_upd_addr", 32'(upd_addr), 0);
    mq.delete(); m_err = 0; m_upd = 0; m_mis = 0; m_addr = '0; m_tk = 0; m_jp = 0;
    @(negedge clk);
    arst_n = 1;
    step();
  endtask

  // Apply this cycle's inputs to the model's list, following the queue rules directly.
  task automatic model_step();
    int     n;
    logic   do_pop, do_push;
    entry_t e;
    n = mq.size();
    m_upd = 0;
    m_mis = 0;
    if (flush) begin
      mq.delete();
    end else begin
      do_pop  = resolve_valid && (n > 0);
      do_push = push_valid && ((n < DEPTH_DEF) || resolve_valid);
      if (push_valid && n == DEPTH_DEF && !resolve_valid) m_err = 1;
      if (resolve_valid && n == 0) m_err = 1;
      if (do_pop) begin
        e = mq.pop_front();
        m_upd  = 1;
        m_addr = e.addr;
        m_tk   = resolve_taken;
        m_jp   = resolve_jump;
        m_mis  = (e.pred != (resolve_taken || resolve_jump));
      end
      if (m_mis) begin
        mq.delete();
      end else if (do_push) begin
        e.addr = push_addr;
        e.pred = push_pred;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    chk("rnd_count", 32'(count), 32'(mq.size()));
    chk("rnd_full", 32'(full), 32'(mq.size() == DEPTH_DEF));
    chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
    chk("rnd_upd_en", 32'(upd_en), 32'(m_upd));
    chk("rnd_mispredict", 32'(mispredict), 32'(m_mis));
    chk("rnd_err", 32'(err), 32'(m_err));
    if (m_upd) begin
      chk("rnd_upd_addr", 32'(upd_addr), 32'(m_addr));
      chk("rnd_upd_taken", 32'(upd_taken), 32'(m_tk));
      chk("rnd_upd_jumped", 32'(upd_jumped), 32'(m_jp));
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       pv;
    logic [4:0] pa;
    logic       pp;
    logic       rv;
    logic       rt;
    logic       rj;
    logic       fl;
    int         e_cnt;
    logic       e_upd;
    logic [4:0] e_addr;
    logic       e_tk;
    logic       e_jp;
    logic       e_mis;
  } vec_t;

  function automatic vec_t mkv(input logic pv, input logic [4:0] pa, input logic pp,
                               input logic rv, input logic rt, input logic rj, input logic fl,
                               input int e_cnt, input logic e_upd, input logic [4:0] e_addr,
                               input logic e_tk, input logic e_jp, input logic e_mis);
    vec_t v;
    v.pv = pv; v.pa = pa; v.pp = pp; v.rv = rv; v.rt = rt; v.rj = rj; v.fl = fl;
    v.e_cnt = e_cnt; v.e_upd = e_upd; v.e_addr = e_addr;
    v.e_tk = e_tk; v.e_jp = e_jp; v.e_mis = e_mis;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    arst_n = 0;
    idle_inputs();

    //                pv pa pp rv rt rj fl   cnt upd addr tk jp mis
    tbl[0]  = mkv(1, 3, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 0, 1, 1, 0, 0,   0, 1, 3, 1, 0, 0); // correct taken prediction
    tbl[2]  = mkv(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(1, 2, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0);
    tbl[4]  = mkv(1, 3, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(0, 0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 0, 1); // mispredict squashes 2 and 3
    tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[7]  = mkv(1, 4, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    tbl[8]  = mkv(1, 5, 1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0);
    tbl[9]  = mkv(1, 6, 1, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0);
    tbl[10] = mkv(1, 7, 1, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    tbl[11] = mkv(1, 8, 1, 1, 1, 0, 0,   4, 1, 4, 1, 0, 0); // push+pop while full
    tbl[12] = mkv(0, 0, 0, 1, 1, 0, 0,   3, 1, 5, 1, 0, 0);
    tbl[13] = mkv(0, 0, 0, 1, 1, 0, 0,   2, 1, 6, 1, 0, 0);
    tbl[14] = mkv(0, 0, 0, 1, 1, 0, 0,   1, 1, 7, 1, 0, 0);
    tbl[15] = mkv(0, 0, 0, 1, 0, 1, 0,   0, 1, 8, 0, 1, 0); // jump counts as taken
    tbl[16] = mkv(1, 9, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    tbl[17] = mkv(0, 0, 0, 1, 0, 0, 0,   0, 1, 9, 0, 0, 1); // predicted taken, fell through

    do_reset();

    for (int i = 0; i < 18; i++) begin
      push_valid = tbl[i].pv; push_addr = tbl[i].pa; push_pred = tbl[i].pp;
      resolve_valid = tbl[i].rv; resolve_taken = tbl[i].rt; resolve_jump = tbl[i].rj;
      flush = tbl[i].fl;
      step();
      chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].e_cnt == 0));
      chk("tbl_full", 32'(full), 32'(tbl[i].e_cnt == DEPTH_DEF));
      chk("tbl_upd_en", 32'(upd_en), 32'(tbl[i].e_upd));
      chk("tbl_mispredict", 32'(mispredict), 32'(tbl[i].e_mis));
      chk("tbl_err", 32'(err), 0);
      if (tbl[i].e_upd) begin
        chk("tbl_upd_addr", 32'(upd_addr), 32'(tbl[i].e_addr));
        chk("tbl_upd_taken", 32'(upd_taken), 32'(tbl[i].e_tk));
        chk("tbl_upd_jumped", 32'(upd_jumped), 32'(tbl[i].e_jp));
      end
    end
    idle_inputs();

    // Resolve on an empty queue: ignored, sticky error.
    do_reset();
    resolve_valid = 1; resolve_taken = 1;
    step();
    idle_inputs();
    chk("empty_res_err", 32'(err), 1);
    chk("empty_res_upd", 32'(upd_en), 0);
    chk("empty_res_count", 32'(count), 0);
    step();
    chk("err_sticky", 32'(err), 1);

    // Push while full: dropped, contents preserved.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_valid = 1; push_addr = 5'(10 + i); push_pred = 1;
      step();
    end
    push_valid = 1; push_addr = 5'd20; push_pred = 1;
    step();
    idle_inputs();
    chk("full_push_err", 32'(err), 1);
    chk("full_push_count", 32'(count), 4);
    chk("full_push_full", 32'(full), 1);
    chk("full_push_upd", 32'(upd_en), 0);
    for (int i = 0; i < 4; i++) begin
      resolve_valid = 1; resolve_taken = 1;
      step();
      chk("drain_addr", 32'(upd_addr), 32'(10 + i));
    end
    idle_inputs();
    step();
    chk("drain_count", 32'(count), 0);
    chk("drain_upd", 32'(upd_en), 0);

    // Flush with push and resolve at count 2; the pulse from the prior resolve survives.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1; push_addr = 5'(1 + i); push_pred = 1;
      step();
    end
    push_valid = 0; resolve_valid = 1; resolve_taken = 1;
    step();
    chk("pre_flush_count", 32'(count), 2);
    flush = 1; push_valid = 1; push_addr = 5'd30; push_pred = 0;
    resolve_valid = 1; resolve_taken = 1;
    #1;
    chk("flush_keeps_pulse", 32'(upd_en), 1);
    step();
    idle_inputs();
    chk("flush_count", 32'(count), 0);
    chk("flush_upd", 32'(upd_en), 0);
    chk("flush_mis", 32'(mispredict), 0);
    chk("flush_empty", 32'(empty), 1);
    step();
    chk("post_flush_upd", 32'(upd_en), 0);

    // Asynchronous reset mid-cycle at count 3 with an update pending.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_valid = 1; push_addr = 5'(1 + i); push_pred = 1;
      step();
    end
    push_valid = 0; resolve_valid = 1; resolve_taken = 1;
    step();
    idle_inputs();
    chk("pre_arst_count", 32'(count), 3);
    #2;
    arst_n = 0;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_upd", 32'(upd_en), 0);
    push_valid = 1; push_addr = 5'd17; push_pred = 0;
    @(negedge clk);
    arst_n = 1;
    step();
    chk("first_push_count", 32'(count), 1);
    push_valid = 0; resolve_valid = 1; resolve_taken = 0;
    step();
    idle_inputs();
    chk("first_push_upd", 32'(upd_en), 1);
    chk("first_push_addr", 32'(upd_addr), 17);
    chk("first_push_mis", 32'(mispredict), 0);

    // Random traffic against the list model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      push_valid    = ($urandom_range(0, 99) < 55);
      push_addr     = 5'($urandom_range(0, 31));
      push_pred     = 1'($urandom_range(0, 1));
      resolve_valid = ($urandom_range(0, 99) < 45);
      resolve_jump  = ($urandom_range(0, 7) == 0);
      resolve_taken = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 99) < 3);
      model_step();
      step();
      check_model();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
